// File: rtl/irrigation_pkg.sv
// ---------------------------------------------------------------------------
// irrigation_pkg
// Shared definitions for the irrigation run timer:
//   - state_t      : run-timer state machine states
//   - calc_div     : clock cycles per count step (CLK_HZ / TICK_HZ)
//   - calc_sdiv    : clock cycles each display digit is held
//   - SEG_LUT      : active-low {a,b,c,d,e,f,g} patterns for digits 0..9
//   - seg_decode   : BCD nibble to segment pattern, blank for non-BCD
// ---------------------------------------------------------------------------
package irrigation_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    PAUSED = 2'd2,
    DONE   = 2'd3
  } state_t;

  function automatic int calc_div(input int clk_hz, input int tick_hz);
    return clk_hz / tick_hz;
  endfunction

  function automatic int calc_sdiv(input int clk_hz, input int scan_hz, input int ndig);
    return clk_hz / (scan_hz * ndig);
  endfunction

  localparam logic [6:0] SEG_LUT [10] = '{
    7'b0000001,  // 0
    7'b1001111,  // 1
    7'b0010010,  // 2
    7'b0000110,  // 3
    7'b1001100,  // 4
    7'b0100100,  // 5
    7'b0100000,  // 6
    7'b0001111,  // 7
    7'b0000000,  // 8
    7'b0000100   // 9
  };

  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  // Anything above 9 cannot be shown as a decimal digit, so it is blanked
  // rather than drawn as a misleading shape.
  function automatic logic [6:0] seg_decode(input logic [3:0] digit);
    logic [6:0] pattern;
    pattern = SEG_BLANK;
    if (digit <= 4'd9) pattern = SEG_LUT[digit];
    return pattern;
  endfunction

endpackage

// File: rtl/irrigation_timer_seg_scan.sv
// ---------------------------------------------------------------------------
// seg_scan
// Multiplexed 7-segment driver for NDIG BCD digits.
//   clk, reset : system clock, asynchronous active-high reset
//   time_bcd   : NDIG packed BCD digits, digit 0 in [3:0]
//   seg        : {a,b,c,d,e,f,g}, active-low, pattern of the enabled digit
//   an         : one-hot active-low digit enables
// Each digit is held for SDIV clock cycles, index 0 first, then wraps.
// ---------------------------------------------------------------------------
module seg_scan
  import irrigation_pkg::*;
#(
  parameter int NDIG = 4,
  parameter int SDIV = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [4*NDIG-1:0] time_bcd,
  output logic [6:0]        seg,
  output logic [NDIG-1:0]   an
);

  localparam int CW = (SDIV > 1) ? $clog2(SDIV) : 1;
  localparam int IW = (NDIG > 1) ? $clog2(NDIG) : 1;

  logic [CW-1:0] hold_cnt;
  logic [IW-1:0] idx;
  logic [IW-1:0] nxt_idx;
  logic [3:0]    nxt_digit;

  // Work out which digit will be enabled after this edge, so that the
  // registered segment pattern and the registered enable switch together.
  always_comb begin
    nxt_idx = idx;
    if (hold_cnt == CW'(SDIV - 1)) begin
      nxt_idx = (idx == IW'(NDIG - 1)) ? '0 : idx + 1'b1;
    end
    nxt_digit = 4'd0;
    for (int i = 0; i < NDIG; i++) begin
      if (nxt_idx == IW'(i)) nxt_digit = time_bcd[4*i +: 4];
    end
  end

  // Free-running scan: hold counter, digit index, and the registered outputs.
  // seg is refreshed every cycle so a time change shows up on the digit
  // currently lit without waiting for the next digit slot.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hold_cnt <= '0;
      idx      <= '0;
      an       <= ~NDIG'(1);
      seg      <= seg_decode(4'd0);
    end else begin
      hold_cnt <= (hold_cnt == CW'(SDIV - 1)) ? '0 : hold_cnt + 1'b1;
      idx      <= nxt_idx;
      an       <= ~(NDIG'(1) << nxt_idx);
      seg      <= seg_decode(nxt_digit);
    end
  end

endmodule

// File: rtl/irrigation_timer.sv
// ---------------------------------------------------------------------------
// irrigation_timer
// Parametrised mm:ss run timer with up-count (stopwatch) and count-down
// (timed valve run) modes, start/pause/clear/load control and a scanned
// 7-segment display.
//   clk, reset  : system clock, asynchronous active-high reset
//   start       : pulse, run from IDLE or resume from PAUSED
//   pause       : pulse, freeze a running count
//   clear       : pulse, time to zero and back to IDLE
//   load        : pulse, load preset_bcd (rejected while running)
//   mode        : 0 up-count, 1 count-down, sampled on start from IDLE
//   preset_bcd  : NDIG BCD digits, [3:0] seconds units
//   time_bcd    : current time, same packing as preset_bcd
//   running     : high in RUN
//   done        : high in DONE
//   tick        : pulse on each count step
//   wrap        : pulse when up-count rolls from all-max to zero
//   load_err    : pulse when a load is rejected as non-BCD / bad seconds
//   seg, an     : active-low segments and digit enables
// ---------------------------------------------------------------------------
module irrigation_timer
  import irrigation_pkg::*;
#(
  parameter int CLK_HZ     = 50_000_000,
  parameter int TICK_HZ    = 1,
  parameter int SCAN_HZ    = 1000,
  parameter int MIN_DIGITS = 2,
  localparam int NDIG      = MIN_DIGITS + 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              pause,
  input  logic              clear,
  input  logic              load,
  input  logic              mode,
  input  logic [4*NDIG-1:0] preset_bcd,
  output logic [4*NDIG-1:0] time_bcd,
  output logic              running,
  output logic              done,
  output logic              tick,
  output logic              wrap,
  output logic              load_err,
  output logic [6:0]        seg,
  output logic [NDIG-1:0]   an
);

  localparam int DIV  = calc_div(CLK_HZ, TICK_HZ);
  localparam int SDIV = calc_sdiv(CLK_HZ, SCAN_HZ, NDIG);
  localparam int PW   = $clog2(DIV);
  localparam int W    = 4 * NDIG;

  state_t        state;
  logic          mode_r;
  logic [PW-1:0] presc;
  logic [W-1:0]  time_inc;
  logic [W-1:0]  time_dec;
  logic          preset_ok;

  // Digit 1 is seconds tens and rolls at 5; every other digit rolls at 9.
  function automatic logic [3:0] digit_max(input int pos);
    return (pos == 1) ? 4'd5 : 4'd9;
  endfunction

  function automatic logic [W-1:0] bcd_inc(input logic [W-1:0] t);
    logic [W-1:0] r;
    logic         carry;
    r     = t;
    carry = 1'b1;
    for (int i = 0; i < NDIG; i++) begin
      if (carry) begin
        if (t[4*i +: 4] == digit_max(i)) begin
          r[4*i +: 4] = 4'd0;
        end else begin
          r[4*i +: 4] = t[4*i +: 4] + 4'd1;
          carry       = 1'b0;
        end
      end
    end
    return r;
  endfunction

  function automatic logic [W-1:0] bcd_dec(input logic [W-1:0] t);
    logic [W-1:0] r;
    logic         borrow;
    r      = t;
    borrow = 1'b1;
    for (int i = 0; i < NDIG; i++) begin
      if (borrow) begin
        if (t[4*i +: 4] == 4'd0) begin
          r[4*i +: 4] = digit_max(i);
        end else begin
          r[4*i +: 4] = t[4*i +: 4] - 4'd1;
          borrow      = 1'b0;
        end
      end
    end
    return r;
  endfunction

  function automatic logic bcd_valid(input logic [W-1:0] p);
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < NDIG; i++) begin
      if (p[4*i +: 4] > digit_max(i)) ok = 1'b0;
    end
    return ok;
  endfunction

  // Next-step candidates for both directions plus preset validation;
  // the state machine picks which one, if any, to commit.
  always_comb begin
    time_inc  = bcd_inc(time_bcd);
    time_dec  = bcd_dec(time_bcd);
    preset_ok = bcd_valid(preset_bcd);
  end

  // Run-timer state machine. Commands are decoded in priority order
  // clear > load > start > pause; a load while running is ignored and
  // falls through so a simultaneous pause still takes effect. The
  // prescaler only advances on RUN cycles with no command acting, which
  // means the pause cycle itself does not consume a prescaler count and
  // a resume continues exactly from the frozen value.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      mode_r   <= 1'b0;
      presc    <= '0;
      time_bcd <= '0;
      running  <= 1'b0;
      done     <= 1'b0;
      tick     <= 1'b0;
      wrap     <= 1'b0;
      load_err <= 1'b0;
    end else begin
      tick     <= 1'b0;
      wrap     <= 1'b0;
      load_err <= 1'b0;
      if (clear) begin
        state    <= IDLE;
        time_bcd <= '0;
        presc    <= '0;
        running  <= 1'b0;
        done     <= 1'b0;
      end else if (load && (state != RUN)) begin
        if (preset_ok) begin
          state    <= IDLE;
          time_bcd <= preset_bcd;
          presc    <= '0;
          running  <= 1'b0;
          done     <= 1'b0;
        end else begin
          load_err <= 1'b1;
        end
      end else if (start && (state == IDLE)) begin
        mode_r <= mode;
        presc  <= '0;
        if (mode && (time_bcd == '0)) begin
          state <= DONE;
          done  <= 1'b1;
        end else begin
          state   <= RUN;
          running <= 1'b1;
        end
      end else if (start && (state == PAUSED)) begin
        state   <= RUN;
        running <= 1'b1;
      end else if (pause && (state == RUN)) begin
        state   <= PAUSED;
        running <= 1'b0;
      end else if (state == RUN) begin
        if (presc == PW'(DIV - 1)) begin
          presc <= '0;
          tick  <= 1'b1;
          if (!mode_r) begin
            time_bcd <= time_inc;
            wrap     <= (time_inc == '0);
          end else begin
            time_bcd <= time_dec;
            if (time_dec == '0) begin
              state   <= DONE;
              running <= 1'b0;
              done    <= 1'b1;
            end
          end
        end else begin
          presc <= presc + 1'b1;
        end
      end
    end
  end

  seg_scan #(
    .NDIG (NDIG),
    .SDIV (SDIV)
  ) u_seg_scan (
    .clk      (clk),
    .reset    (reset),
    .time_bcd (time_bcd),
    .seg      (seg),
    .an       (an)
  );

endmodule
